sb_tx_packet_framer_mp: RTL and testbench

Next-generation sideband TX packet framer. It accepts whole messages (header plus 0..MAX_DPH data phases) into a small message queue and computes control and data parity. It emits framed PHASE_W-bit phases to the sideband serializer under a valid/ready handshake. It sits between the LTSM/RDI message generators and the sideband serializer, and adds width/depth parametrisation, multi-phase payloads, queuing and back-pressure.

---
 rtl/sb_tx_packet_framer_mp.sv | 193 +++++++++++++++++++
 tb/tb_sb_tx_packet_framer_mp.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_tx_packet_framer_mp.sv
// Sideband TX packet framer: queues whole messages with precomputed parity and
// streams header/data phases to the serializer under valid/ready.
//
// state  | meaning
// S_IDLE | nothing in flight, o_phase_valid low
// S_HDR  | header phase {dp, cp, header} presented
// S_DATA | data phase presented, rem_q further phases still to go
module sb_tx_packet_framer_mp #(
  parameter  int PHASE_W     = 64,
  parameter  int MAX_DPH     = 2,
  parameter  int DEPTH       = 4,
  parameter  int TIMEOUT_OPC = 5,
  localparam int NDPH_W      = $clog2(MAX_DPH + 1),
  localparam int LVL_W       = $clog2(DEPTH + 1),
  localparam int PTR_W       = $clog2(DEPTH)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_msg_valid,
  output logic                       o_msg_ready,
  input  logic [PHASE_W-3:0]         i_header,
  input  logic [MAX_DPH*PHASE_W-1:0] i_data,
  input  logic [NDPH_W-1:0]          i_num_dph,
  output logic [PHASE_W-1:0]         o_phase,
  output logic                       o_phase_valid,
  input  logic                       i_ser_ready,
  output logic                       o_timeout_ctr_start,
  output logic [LVL_W-1:0]           o_queue_level,
  output logic                       o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  localparam logic [NDPH_W-1:0] MAX_DPH_N = NDPH_W'(MAX_DPH);
  localparam logic [LVL_W-1:0]  DEPTH_L   = LVL_W'(DEPTH);
  localparam logic [3:0]        TMO_OPC   = 4'(TIMEOUT_OPC);

  // Message storage; the header entry already carries {dp, cp}.
  logic [PHASE_W-1:0]         q_hdr_q  [DEPTH];
  logic [MAX_DPH*PHASE_W-1:0] q_data_q [DEPTH];
  logic [NDPH_W-1:0]          q_ndph_q [DEPTH];

  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]           level_q, level_d;
  state_t                     state_q, state_d;
  logic [PHASE_W-1:0]         phase_q, phase_d;
  logic [MAX_DPH*PHASE_W-1:0] cur_data_q, cur_data_d;
  logic [NDPH_W-1:0]          cur_ndph_q, cur_ndph_d;
  logic [NDPH_W-1:0]          rem_q, rem_d;
  logic                       cur_tmo_q, cur_tmo_d;
  logic                       tmo_pulse_q, tmo_pulse_d;

  logic                       full;
  logic                       empty;
  logic                       push;
  logic                       pop;
  logic                       hs;
  logic                       next_msg;
  logic                       in_cp;
  logic                       in_dp;
  logic [NDPH_W-1:0]          in_ndph;
  logic [PHASE_W-1:0]         in_hdr_phase;

  assign full  = (level_q == DEPTH_L);
  assign empty = (level_q == '0);
  assign push  = i_msg_valid && !full;
  assign hs    = (state_q != S_IDLE) && i_ser_ready;

  always_comb begin : enq_parity
    in_ndph = (i_num_dph > MAX_DPH_N) ? MAX_DPH_N : i_num_dph;
    in_cp   = ^i_header;
    in_dp   = 1'b0;
    for (int i = 0; i < MAX_DPH; i++) begin
      if (i < int'(in_ndph)) begin
        in_dp = in_dp ^ (^i_data[i*PHASE_W +: PHASE_W]);
      end
    end
    in_hdr_phase = {in_dp, in_cp, i_header};
  end

  always_ff @(posedge i_clk) begin : queue_store
    if (push) begin
      q_hdr_q[wr_ptr_q]  <= in_hdr_phase;
      q_data_q[wr_ptr_q] <= i_data;
      q_ndph_q[wr_ptr_q] <= in_ndph;
    end
  end

  always_comb begin : queue_ctrl
    wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (!push && pop) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  // Data phases are shifted out of cur_data_q; rem_q counts down to the last one.
  always_comb begin : fsm_next
    state_d     = state_q;
    phase_d     = phase_q;
    cur_data_d  = cur_data_q;
    cur_ndph_d  = cur_ndph_q;
    rem_d       = rem_q;
    cur_tmo_d   = cur_tmo_q;
    tmo_pulse_d = 1'b0;
    next_msg    = 1'b0;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: next_msg = 1'b1;
      S_HDR: begin
        if (hs) begin
          tmo_pulse_d = cur_tmo_q;
          if (cur_ndph_q != '0) begin
            state_d    = S_DATA;
            phase_d    = cur_data_q[PHASE_W-1:0];
            cur_data_d = cur_data_q >> PHASE_W;
            rem_d      = cur_ndph_q - NDPH_W'(1);
          end else begin
            next_msg = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (hs) begin
          if (rem_q == '0) begin
            next_msg = 1'b1;
          end else begin
            phase_d    = cur_data_q[PHASE_W-1:0];
            cur_data_d = cur_data_q >> PHASE_W;
            rem_d      = rem_q - NDPH_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Pulling the next header in the same edge keeps back-to-back messages bubble-free.
    if (next_msg) begin
      if (!empty) begin
        pop        = 1'b1;
        state_d    = S_HDR;
        phase_d    = q_hdr_q[rd_ptr_q];
        cur_data_d = q_data_q[rd_ptr_q];
        cur_ndph_d = q_ndph_q[rd_ptr_q];
        cur_tmo_d  = (q_hdr_q[rd_ptr_q][17:14] == TMO_OPC);
      end else begin
        state_d = S_IDLE;
        phase_d = '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin : regs
    if (!i_rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      state_q     <= S_IDLE;
      phase_q     <= '0;
      cur_data_q  <= '0;
      cur_ndph_q  <= '0;
      rem_q       <= '0;
      cur_tmo_q   <= 1'b0;
      tmo_pulse_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      state_q     <= state_d;
      phase_q     <= phase_d;
      cur_data_q  <= cur_data_d;
      cur_ndph_q  <= cur_ndph_d;
      rem_q       <= rem_d;
      cur_tmo_q   <= cur_tmo_d;
      tmo_pulse_q <= tmo_pulse_d;
    end
  end

  assign o_msg_ready         = !full;
  assign o_phase             = phase_q;
  assign o_phase_valid       = (state_q != S_IDLE);
  assign o_timeout_ctr_start = tmo_pulse_q;
  assign o_queue_level       = level_q;
  assign o_busy              = !empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_sb_tx_packet_framer_mp.sv
// Scoreboard bench for sb_tx_packet_framer_mp: stimulus pushes hand-computed
// phases, a negedge monitor pops and compares on every phase handshake.
module tb_sb_tx_packet_framer_mp;

  logic         clk = 1'b0;
  logic         i_rst_n;
  logic         i_msg_valid;
  logic         o_msg_ready;
  logic [61:0]  i_header;
  logic [127:0] i_data;
  logic [1:0]   i_num_dph;
  logic [63:0]  o_phase;
  logic         o_phase_valid;
  logic         i_ser_ready;
  logic         o_timeout_ctr_start;
  logic [2:0]   o_queue_level;
  logic         o_busy;

  typedef struct {
    logic [63:0] ph;
    bit          tmo;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_err = 0;
  bit          prev_tmo_hs = 1'b0;
  bit          hold_v = 1'b0;
  logic [63:0] hold_phase = '0;

  sb_tx_packet_framer_mp #(
    .PHASE_W(64), .MAX_DPH(2), .DEPTH(4), .TIMEOUT_OPC(5)
  ) dut (
    .i_clk(clk),
    .i_rst_n(i_rst_n),
    .i_msg_valid(i_msg_valid),
    .o_msg_ready(o_msg_ready),
    .i_header(i_header),
    .i_data(i_data),
    .i_num_dph(i_num_dph),
    .o_phase(o_phase),
    .o_phase_valid(o_phase_valid),
    .i_ser_ready(i_ser_ready),
    .o_timeout_ctr_start(o_timeout_ctr_start),
    .o_queue_level(o_queue_level),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: phase compare on handshake, hold stability, timeout pulse timing.
  always @(negedge clk) begin
    if (!i_rst_n) begin
      prev_tmo_hs = 1'b0;
      hold_v      = 1'b0;
    end else begin
      chk("tmo_pulse", 64'(o_timeout_ctr_start), 64'(prev_tmo_hs));
      prev_tmo_hs = 1'b0;
      if (hold_v) begin
        chk("hold_valid", 64'(o_phase_valid), 64'd1);
        chk("hold_phase", o_phase, hold_phase);
      end
      hold_v     = o_phase_valid && !i_ser_ready;
      hold_phase = o_phase;
      if (o_phase_valid && i_ser_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_phase: got %h expected none", o_phase);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("phase", o_phase, e.ph);
          prev_tmo_hs = e.tmo;
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [61:0] hdr, input logic [127:0] data, input logic [1:0] ndph,
                      input bit exp_acc, input logic [63:0] e0, input logic [63:0] e1,
                      input logic [63:0] e2, input int n_exp, input bit tmo);
    i_msg_valid = 1'b1;
    i_header    = hdr;
    i_data      = data;
    i_num_dph   = ndph;
    chk("msg_ready", 64'(o_msg_ready), 64'(exp_acc));
    if (exp_acc) begin
      sb.push_back(exp_t'{e0, tmo});
      if (n_exp > 1) sb.push_back(exp_t'{e1, 1'b0});
      if (n_exp > 2) sb.push_back(exp_t'{e2, 1'b0});
    end
    @(posedge clk);
    #1;
    i_msg_valid = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: outstanding %0d expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n     = 1'b0;
    i_msg_valid = 1'b0;
    i_header    = '0;
    i_data      = '0;
    i_num_dph   = '0;
    i_ser_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", 64'(o_phase_valid), 64'd0);
    chk("rst_phase", o_phase, 64'd0);
    chk("rst_level", 64'(o_queue_level), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_ready", 64'(o_msg_ready), 64'd1);

    // Header-only message, latency and return to idle
    sync();
    i_ser_ready = 1'b1;
    send(62'h1, '0, 2'd0, 1'b1, 64'h4000_0000_0000_0001, '0, '0, 1, 1'b0);
    @(negedge clk);
    chk("t1_valid_pre", 64'(o_phase_valid), 64'd0);
    chk("t1_level", 64'(o_queue_level), 64'd1);
    @(negedge clk);
    chk("t1_valid", 64'(o_phase_valid), 64'd1);
    @(negedge clk);
    chk("t1_valid_post", 64'(o_phase_valid), 64'd0);
    chk("t1_busy_post", 64'(o_busy), 64'd0);
    drain(20);

    // Two data phases, dp over both
    sync();
    send(62'h0, {64'h1, 64'h3}, 2'd2, 1'b1, 64'h8000_0000_0000_0000, 64'h3, 64'h1, 3, 1'b0);
    drain(30);

    // Timeout opcode with serializer stalled for 5 cycles
    sync();
    i_ser_ready = 1'b0;
    send(62'h14000, '0, 2'd0, 1'b1, 64'h0000_0000_0001_4000, '0, '0, 1, 1'b1);
    repeat (5) @(negedge clk);
    chk("t3_stall_phase", o_phase, 64'h0000_0000_0001_4000);
    chk("t3_stall_pulse", 64'(o_timeout_ctr_start), 64'd0);
    sync();
    i_ser_ready = 1'b1;
    drain(20);

    // Fill: 1 in flight + 4 queued, sixth dropped, then bubble-free drain
    sync();
    i_ser_ready = 1'b0;
    send(62'h10, '0, 2'd0, 1'b1, 64'h4000_0000_0000_0010, '0, '0, 1, 1'b0);
    send(62'h11, '0, 2'd0, 1'b1, 64'h0000_0000_0000_0011, '0, '0, 1, 1'b0);
    send(62'h12, {64'h0, 64'hFF}, 2'd1, 1'b1, 64'h0000_0000_0000_0012, 64'hFF, '0, 2, 1'b0);
    send(62'h13, '0, 2'd0, 1'b1, 64'h4000_0000_0000_0013, '0, '0, 1, 1'b0);
    send(62'h14, '0, 2'd0, 1'b1, 64'h0000_0000_0000_0014, '0, '0, 1, 1'b0);
    send(62'h15, '0, 2'd0, 1'b0, 64'h0000_0000_0000_0015, '0, '0, 1, 1'b0);
    @(negedge clk);
    chk("t4_level_full", 64'(o_queue_level), 64'd4);
    chk("t4_ready_full", 64'(o_msg_ready), 64'd0);
    chk("t4_busy", 64'(o_busy), 64'd1);
    sync();
    i_ser_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t4_no_bubble", 64'(o_phase_valid), 64'd1);
    end
    drain(20);
    chk("t4_idle_valid", 64'(o_phase_valid), 64'd0);
    chk("t4_idle_level", 64'(o_queue_level), 64'd0);

    // num_dph above MAX_DPH clamps; num_dph=1 excludes phase 1 from dp
    sync();
    send(62'h3, {64'h1, 64'h6}, 2'd3, 1'b1, 64'h8000_0000_0000_0003, 64'h6, 64'h1, 3, 1'b0);
    drain(30);
    sync();
    send(62'h0, {64'h1, 64'h2}, 2'd1, 1'b1, 64'h8000_0000_0000_0000, 64'h2, '0, 2, 1'b0);
    drain(30);

    // Reset during data phase 1 with two messages queued
    sync();
    i_ser_ready = 1'b0;
    send(62'h20, {64'hB, 64'hA}, 2'd2, 1'b1, 64'hC000_0000_0000_0020, 64'hA, 64'hB, 3, 1'b0);
    send(62'h21, '0, 2'd0, 1'b1, 64'h0000_0000_0000_0021, '0, '0, 1, 1'b0);
    send(62'h22, '0, 2'd0, 1'b1, 64'h0000_0000_0000_0022, '0, '0, 1, 1'b0);
    i_ser_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    i_ser_ready = 1'b0;
    @(negedge clk);
    chk("t6_pre_phase", o_phase, 64'h0000_0000_0000_000B);
    chk("t6_pre_level", 64'(o_queue_level), 64'd2);
    #1;
    i_rst_n = 1'b0;
    sb.delete();
    #1;
    chk("t6_rst_phase", o_phase, 64'd0);
    chk("t6_rst_valid", 64'(o_phase_valid), 64'd0);
    chk("t6_rst_level", 64'(o_queue_level), 64'd0);
    chk("t6_rst_busy", 64'(o_busy), 64'd0);
    chk("t6_rst_pulse", 64'(o_timeout_ctr_start), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    i_rst_n     = 1'b1;
    i_ser_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t6_quiet", 64'(o_phase_valid), 64'd0);
    end
    sync();
    send(62'h1, '0, 2'd0, 1'b1, 64'h4000_0000_0000_0001, '0, '0, 1, 1'b0);
    drain(20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
